hc_dsm_writer: RTL and testbench
================================

Name: hc_dsm_writer

Overview:
Completion-status writer beside hc_requestor, driven by the same start/finish pair as gaussian_wrapper.
- Measures accelerator run time from start to finish.
- On finish, issues one CCI-P cache-line write of a status record to the DSM line at hc_dsm_base.
- Waits for the write response, then pulses done.
- Its c1 Tx output is muxed with hc_requestor's c1 Tx at the top level; the top-level mux gives priority to hc_requestor.

Parameters:
MDATA_TAG, 16'hD5A0, mdata value stamped on the DSM write; the response is matched on it.
CNT_WIDTH, 64, width of the cycle counter and the run counter (max 64).

Ports:
clk  input  1  CCI-P primary clock (pClk domain).
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse: accelerator run begins.
finish  input  1  single-cycle pulse: accelerator run complete.
hc_dsm_base  input  t_hc_address  DSM cache-line address (from hc_csr).
ccip_rx  input  t_if_ccip_Rx  CCI-P Rx; uses c1TxAlmFull, c1.rspValid, c1.hdr.mdata.
ccip_c1_tx  output  t_if_ccip_c1_Tx  write request channel.
c1_grant  input  1  top-level mux accepted ccip_c1_tx this cycle.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the DSM write is acknowledged.

Behaviour:
- Reset values (synchronous, active-high, on clk): state=IDLE, cycle_cnt=0, run_cnt=0, ccip_c1_tx.valid=0, busy=0, done=0.
- ccip_c1_tx is registered; hdr and data are held stable while valid=1.
- IDLE:
  - start -> RUN; cycle_cnt cleared to 0 on that cycle.
  - finish while IDLE is ignored.
- RUN:
  - cycle_cnt += 1 each cycle; saturates at all-ones, no wrap.
  - finish -> REQ; the final count includes the finish cycle.
  - Another start restarts the count (cycle_cnt=0) and stays in RUN.
  - start and finish in the same cycle: finish wins.
- REQ:
  - If !ccip_rx.c1TxAlmFull: drive valid=1.
  - Header: req_type=eREQ_WRLINE_I, vc_sel=eVC_VA, cl_len=eCL_LEN_1, sop=1, address=hc_dsm_base, mdata=MDATA_TAG.
  - Data: bit[0]=1 (complete), [63:32]=32'h4843_0001 (magic), [127:64]=cycle_cnt, [191:128]=run_cnt, remainder 0.
  - Hold valid until c1_grant=1; on grant: valid=0 next cycle -> WAIT_RSP.
  - almFull rising while valid=1: keep valid asserted (the mux owns flow control); no new valid is raised while almFull=1.
- WAIT_RSP:
  - Waits for ccip_rx.c1.rspValid with hdr.mdata==MDATA_TAG; other responses are ignored (they belong to hc_requestor).
  - Matching response: run_cnt += 1 (wraps), done=1 for exactly one cycle -> IDLE.
  - A matching rspValid seen in REQ is a protocol error and is ignored.
- start in REQ or WAIT_RSP is ignored; a run cannot begin until the DSM write of the previous run is acknowledged.
- Reset mid-operation: return to IDLE next cycle, valid deasserted, done suppressed.
  - A late response for an abandoned write arriving in IDLE is ignored.
- Latency:
  - finish to valid: 1 cycle when almFull=0.
  - response to done: 1 cycle.

Optional Feature:
HC_DSM_STALL_CNT_EN
- Defined: adds a CNT_WIDTH-bit stall_cnt, cleared on start, incremented each cycle in REQ while almFull=1 or (valid=1 and c1_grant=0), saturating. Written to data [255:192].
- Not defined: no counter logic; data [255:192]=0.

Decomposition:
- hc_pkg gains:
  - t_hc_dsm_state enum (IDLE, RUN, REQ, WAIT_RSP);
  - HC_DSM_MAGIC constant;
  - packed struct t_hc_dsm_record (complete, magic, cycles, runs, stalls) cast onto t_ccip_clData.
- One sub-module: hc_sat_counter (width-parameterised, clear/enable, saturating), used for cycle_cnt and stall_cnt.

Test Plan:
1. start, 100 idle cycles, finish, almFull=0, c1_grant immediately -> one WRLINE_I to hc_dsm_base; data[127:64]=101, data[191:128]=0, data[0]=1; done one cycle after the MDATA_TAG response.
2. Two back-to-back runs (cycle counts 5, then 7) -> second record has cycles=7, runs=1.
3. almFull=1 for 20 cycles after finish -> valid stays 0 until almFull drops. With HC_DSM_STALL_CNT_EN, data[255:192]=20; without it, 0.
4. Response with mdata=16'h0003 in WAIT_RSP -> no done; later MDATA_TAG response -> done pulse.
5. reset asserted in WAIT_RSP -> IDLE, busy=0; the subsequent MDATA_TAG response produces no done.
6. finish in IDLE, then start+finish in the same cycle in RUN -> first ignored; second enters REQ with cycles=count including that cycle.

Source files
------------

// File: rtl/hc_dsm_writer_pkg.sv
// Shared types for the DSM completion-status writer: trimmed CCI-P c1 types, FSM states, status record.
// Optional HC_DSM_STALL_CNT_EN adds a stall counter to the record (see hc_dsm_writer).
package hc_dsm_writer_pkg;

  localparam int unsigned HC_ADDR_W = 42;
  localparam int unsigned CL_DATA_W = 512;
  localparam int unsigned MDATA_W   = 16;
  localparam int unsigned REC_W     = 64;

  localparam logic [31:0] HC_DSM_MAGIC = 32'h4843_0001;

  typedef logic [HC_ADDR_W-1:0] t_hc_address;
  typedef logic [CL_DATA_W-1:0] t_ccip_clData;
  typedef logic [MDATA_W-1:0]   t_ccip_mdata;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]   rsvd1;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd0;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_hc_address  address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc    vc_used;
    logic        rsvd;
    logic        format;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REQ      = 2'd2,
    WAIT_RSP = 2'd3
  } t_hc_dsm_state;

  // Status record laid out MSB-first so bit 0 is the complete flag.
  typedef struct packed {
    logic [255:0]     rsvd_hi;
    logic [REC_W-1:0] stalls;
    logic [REC_W-1:0] runs;
    logic [REC_W-1:0] cycles;
    logic [31:0]      magic;
    logic [30:0]      rsvd_lo;
    logic             complete;
  } t_hc_dsm_record;

  function automatic t_ccip_clData hc_dsm_pack(input logic [REC_W-1:0] cycles,
                                               input logic [REC_W-1:0] runs,
                                               input logic [REC_W-1:0] stalls);
    t_hc_dsm_record rec;
    rec          = '0;
    rec.complete = 1'b1;
    rec.magic    = HC_DSM_MAGIC;
    rec.cycles   = cycles;
    rec.runs     = runs;
    rec.stalls   = stalls;
    return CL_DATA_W'(rec);
  endfunction

endpackage

// File: rtl/hc_dsm_writer_if.sv
// CCI-P c1 write path between the DSM writer (master) and the top-level c1 mux (slave).
interface hc_dsm_writer_if;
  import hc_dsm_writer_pkg::*;

  t_if_ccip_Rx    ccip_rx;
  t_if_ccip_c1_Tx ccip_c1_tx;
  logic           c1_grant;

  modport master (input ccip_rx, input c1_grant, output ccip_c1_tx);
  modport slave  (output ccip_rx, output c1_grant, input ccip_c1_tx);

endinterface

// File: rtl/hc_dsm_writer_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear; exposes its next value.
module hc_dsm_writer_sat_counter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign next_c = count_d;

endmodule

// File: rtl/hc_dsm_writer.sv
// Times an accelerator run (start..finish) and posts a completion record to the DSM line, then pulses done.
// Define HC_DSM_STALL_CNT_EN to also record c1 back-pressure cycles in data[255:192].
module hc_dsm_writer
  import hc_dsm_writer_pkg::*;
#(
  parameter logic [15:0] MDATA_TAG = 16'hD5A0,
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   finish,
  input  t_hc_address            hc_dsm_base,
  hc_dsm_writer_if.master        bus,
  output logic                   busy,
  output logic                   done
);

  t_hc_dsm_state  state_q, state_d;
  t_if_ccip_c1_Tx tx_q, tx_d;
  t_if_ccip_c1_Tx new_req_c;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic alm_full_c, rsp_match_c;
  logic cyc_clr_c, cyc_en_c;
  logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_nxt_c;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_nxt_c;
  logic unused_c;

  assign alm_full_c  = bus.ccip_rx.c1TxAlmFull;
  assign rsp_match_c = bus.ccip_rx.c1.rspValid && (bus.ccip_rx.c1.hdr.mdata == MDATA_TAG);

  // A start clears the count unless a finish arrives in the same cycle (finish wins).
  assign cyc_clr_c = start && ((state_q == IDLE) || ((state_q == RUN) && !finish));
  assign cyc_en_c  = (state_q == RUN) && (finish || !start);

  hc_dsm_writer_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cyc_clr_c),
    .en     (cyc_en_c),
    .count  (cyc_cnt_q),
    .next_c (cyc_nxt_c)
  );

`ifdef HC_DSM_STALL_CNT_EN
  logic stall_en_c;
  assign stall_en_c = (state_q == REQ) && (alm_full_c || (tx_q.valid && !bus.c1_grant));

  hc_dsm_writer_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cyc_clr_c),
    .en     (stall_en_c),
    .count  (stall_cnt_q),
    .next_c (stall_nxt_c)
  );
`else
  assign stall_cnt_q = '0;
  assign stall_nxt_c = '0;
`endif

  // Record is built from next-cycle counter values so the finish cycle itself is counted.
  always_comb begin
    new_req_c              = '0;
    new_req_c.hdr.vc_sel   = eVC_VA;
    new_req_c.hdr.sop      = 1'b1;
    new_req_c.hdr.cl_len   = eCL_LEN_1;
    new_req_c.hdr.req_type = eREQ_WRLINE_I;
    new_req_c.hdr.address  = hc_dsm_base;
    new_req_c.hdr.mdata    = MDATA_TAG;
    new_req_c.data         = hc_dsm_pack(REC_W'(cyc_nxt_c), REC_W'(run_cnt_q), REC_W'(stall_nxt_c));
    new_req_c.valid        = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    run_cnt_d = run_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (finish) begin
          state_d = REQ;
          if (!alm_full_c) begin
            tx_d = new_req_c;
          end
        end
      end
      REQ: begin
        // Once raised, valid is held regardless of almFull until the mux grants it.
        if (tx_q.valid) begin
          if (bus.c1_grant) begin
            tx_d.valid = 1'b0;
            state_d    = WAIT_RSP;
          end
        end else if (!alm_full_c) begin
          tx_d = new_req_c;
        end
      end
      WAIT_RSP: begin
        if (rsp_match_c) begin
          run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      run_cnt_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      run_cnt_q <= run_cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ccip_c1_tx = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // Rx fields owned by other consumers, plus counter outputs only read via their next value.
  assign unused_c = ^{bus.ccip_rx.c0TxAlmFull, bus.ccip_rx.c1.hdr, cyc_cnt_q, stall_cnt_q};

endmodule

// File: tb/tb_hc_dsm_writer.sv
// Self-checking bench for hc_dsm_writer: directed vector table, corner-case sequences, randomized runs.
module tb_hc_dsm_writer;
  import hc_dsm_writer_pkg::*;

  localparam logic [15:0] TAG = 16'hD5A0;

  logic        clk = 1'b0;
  logic        reset, start, finish;
  t_hc_address base;
  logic        busy, done;

  hc_dsm_writer_if bus();

  hc_dsm_writer #(.MDATA_TAG(TAG), .CNT_WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .finish      (finish),
    .hc_dsm_base (base),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int runs_model = 0;

  typedef struct {
    int      gap;
    int      rgap;
    bit      sf_same;
    int      hold;
    int      gdly;
    bit      foreign;
    bit      start_in_wait;
    longint  exp_cycles;
    int      exp_runs;
    int      exp_hold_stalls;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rsp(input logic [15:0] md);
    bus.ccip_rx.c1.rspValid  = 1'b1;
    bus.ccip_rx.c1.hdr.mdata = md;
    tick();
    bus.ccip_rx.c1.rspValid  = 1'b0;
  endtask

  function automatic longint stall_expect(input int hold);
`ifdef HC_DSM_STALL_CNT_EN
    return longint'(hold);
`else
    return 0;
`endif
  endfunction

  task automatic check_record(input string tag, input t_hc_address a, input longint cyc,
                              input longint runs, input longint stalls);
    logic [511:0] d;
    d = bus.ccip_c1_tx.data;
    chk({tag, ".valid"},    64'(bus.ccip_c1_tx.valid), 64'(1));
    chk({tag, ".req_type"}, 64'(bus.ccip_c1_tx.hdr.req_type), 64'(4'h0));
    chk({tag, ".vc_sel"},   64'(bus.ccip_c1_tx.hdr.vc_sel), 64'(2'h0));
    chk({tag, ".cl_len"},   64'(bus.ccip_c1_tx.hdr.cl_len), 64'(2'h0));
    chk({tag, ".sop"},      64'(bus.ccip_c1_tx.hdr.sop), 64'(1));
    chk({tag, ".address"},  64'(bus.ccip_c1_tx.hdr.address), 64'(a));
    chk({tag, ".mdata"},    64'(bus.ccip_c1_tx.hdr.mdata), 64'(TAG));
    chk({tag, ".complete"}, 64'(d[0]), 64'(1));
    chk({tag, ".pad_lo"},   64'(d[31:1]), 64'(0));
    chk({tag, ".magic"},    64'(d[63:32]), 64'(32'h4843_0001));
    chk({tag, ".cycles"},   d[127:64], 64'(cyc));
    chk({tag, ".runs"},     d[191:128], 64'(runs));
    chk({tag, ".stalls"},   d[255:192], 64'(stalls));
    chk({tag, ".pad_hi"},   64'(|d[511:256]), 64'(0));
  endtask

  // One complete run from start to done, checked at fixed cycle offsets.
  task automatic do_run(input string tag, input int gap, input int rgap, input bit sf,
                        input int hold, input int gdly, input bit foreign, input bit siw,
                        input longint exp_cyc, input longint exp_runs, input longint exp_stall);
    t_hc_address a;
    a = t_hc_address'({$urandom(), $urandom()});
    base = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_run"}, 64'(busy), 64'(1));
    repeat (gap) tick();
    if (rgap >= 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (rgap) tick();
    end
    finish = 1'b1;
    start  = sf;
    bus.ccip_rx.c1TxAlmFull = (hold > 0);
    tick();
    finish = 1'b0;
    start  = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk({tag, ".no_valid_almfull"}, 64'(bus.ccip_c1_tx.valid), 64'(0));
        tick();
      end
      bus.ccip_rx.c1TxAlmFull = 1'b0;
      tick();
    end
    check_record(tag, a, exp_cyc, exp_runs, exp_stall);
    for (int i = 0; i < gdly; i++) begin
      base = ~a;
      bus.ccip_rx.c1TxAlmFull = (i % 2 == 0);
      tick();
      chk({tag, ".valid_held"}, 64'(bus.ccip_c1_tx.valid), 64'(1));
      chk({tag, ".addr_held"},  64'(bus.ccip_c1_tx.hdr.address), 64'(a));
      chk({tag, ".cyc_held"},   bus.ccip_c1_tx.data[127:64], 64'(exp_cyc));
    end
    bus.ccip_rx.c1TxAlmFull = 1'b0;
    bus.c1_grant = 1'b1;
    tick();
    bus.c1_grant = 1'b0;
    chk({tag, ".valid_drop"}, 64'(bus.ccip_c1_tx.valid), 64'(0));
    chk({tag, ".busy_wait"},  64'(busy), 64'(1));
    if (siw) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (foreign) begin
      send_rsp(16'h0003);
      chk({tag, ".foreign_no_done"}, 64'(done), 64'(0));
      chk({tag, ".foreign_busy"},    64'(busy), 64'(1));
    end
    send_rsp(TAG);
    chk({tag, ".done"},      64'(done), 64'(1));
    chk({tag, ".busy_idle"}, 64'(busy), 64'(0));
    tick();
    chk({tag, ".done_once"}, 64'(done), 64'(0));
    runs_model++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4,   -1, 0, 0,  0, 0, 0, 5,   0, 0};
    tbl[1] = '{6,   -1, 0, 0,  0, 0, 0, 7,   1, 0};
    tbl[2] = '{100, -1, 0, 0,  0, 0, 0, 101, 2, 0};
    tbl[3] = '{10,  -1, 0, 20, 0, 0, 0, 11,  3, 20};
    tbl[4] = '{3,   -1, 0, 0,  0, 1, 0, 4,   4, 0};
    tbl[5] = '{8,   -1, 1, 0,  0, 0, 0, 9,   5, 0};
    tbl[6] = '{10,   5, 0, 0,  0, 0, 0, 6,   6, 0};
    tbl[7] = '{0,   -1, 0, 0,  3, 1, 1, 1,   7, 0};

    reset = 1'b1; start = 1'b0; finish = 1'b0; base = '0;
    bus.ccip_rx = '0;
    bus.c1_grant = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset.busy",  64'(busy), 64'(0));
    chk("reset.valid", 64'(bus.ccip_c1_tx.valid), 64'(0));
    chk("reset.done",  64'(done), 64'(0));

    // finish while idle must be ignored
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("idle_finish.busy",  64'(busy), 64'(0));
    tick();
    chk("idle_finish.valid", 64'(bus.ccip_c1_tx.valid), 64'(0));

    for (int i = 0; i < 8; i++) begin
      do_run($sformatf("vec%0d", i), tbl[i].gap, tbl[i].rgap, tbl[i].sf_same, tbl[i].hold,
             tbl[i].gdly, tbl[i].foreign, tbl[i].start_in_wait, tbl[i].exp_cycles,
             longint'(tbl[i].exp_runs), stall_expect(tbl[i].exp_hold_stalls));
    end

    // reset while waiting for the response; the late response must not produce done
    base = t_hc_address'(42'h1234);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    finish = 1'b1; tick(); finish = 1'b0;
    chk("rst_wait.valid", 64'(bus.ccip_c1_tx.valid), 64'(1));
    bus.c1_grant = 1'b1; tick(); bus.c1_grant = 1'b0;
    chk("rst_wait.busy_before", 64'(busy), 64'(1));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_wait.busy",  64'(busy), 64'(0));
    chk("rst_wait.valid_off", 64'(bus.ccip_c1_tx.valid), 64'(0));
    chk("rst_wait.done",  64'(done), 64'(0));
    send_rsp(TAG);
    chk("rst_wait.late_rsp_done", 64'(done), 64'(0));
    chk("rst_wait.late_rsp_busy", 64'(busy), 64'(0));
    runs_model = 0;

    // randomized runs against the spec-level model
    for (int n = 0; n < 20; n++) begin
      int gap, rgap, hold, gdly;
      bit sf, foreign, siw;
      longint exp_cyc;
      gap     = int'($urandom_range(0, 40));
      rgap    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      sf      = 1'($urandom_range(0, 1));
      hold    = int'($urandom_range(0, 6));
      gdly    = int'($urandom_range(0, 3));
      foreign = 1'($urandom_range(0, 1));
      siw     = 1'($urandom_range(0, 1));
      exp_cyc = longint'(((rgap >= 0) ? rgap : gap) + 1);
      do_run($sformatf("rnd%0d", n), gap, rgap, sf, hold, gdly, foreign, siw,
             exp_cyc, longint'(runs_model), stall_expect(hold));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
